ic_refill_ctrl: RTL and testbench

Direct-mapped instruction cache with a line-refill state machine, sitting in the fetch stage of the pipelined RISC-V core. It produces `instr_hit_f_o` and the fetched instruction for the hazard unit and decode stage. On a miss it fetches a full line from the memory side through a request/beat handshake. A refill starts only while the branch logic asserts `ic_repl_permit_i`, so mispredicted fetch addresses never pull lines in.

---
 rtl/ic_refill_ctrl.sv | 124 ++++++++++++
 tb/tb_ic_refill_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_refill_ctrl.sv
// Direct-mapped instruction cache with a line-refill FSM for the fetch stage.
// Define IC_PERF_CNT_EN to add saturating hit/miss performance counters.
module ic_refill_ctrl #(
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  input  logic        ic_repl_permit_i,
  output logic [31:0] instr_f_o,
  output logic        instr_hit_f_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef IC_PERF_CNT_EN
  ,
  output logic [31:0] ic_hit_cnt_o,
  output logic [31:0] ic_miss_cnt_o
`endif
);

  localparam int WW  = $clog2(LINE_WORDS);
  localparam int IW  = $clog2(SETS);
  localparam int OFF = WW + 2;
  localparam int TW  = 32 - OFF - IW;
  localparam logic [WW-1:0] LAST = WW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

  state_t          state;
  logic [WW-1:0]   cnt;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_mem  [SETS];
  logic [31:0]     data_mem [SETS][LINE_WORDS];

  logic [WW-1:0] word;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic [31:0]   line_addr;
  logic          hit;
  logic          miss_start;
  logic          unused_bits;

  assign word      = pc_f_i[OFF-1:2];
  assign idx       = pc_f_i[OFF+IW-1:OFF];
  assign tag       = pc_f_i[31:OFF+IW];
  assign line_addr = {pc_f_i[31:OFF], {OFF{1'b0}}};

  // The latched request address doubles as miss_addr, so pc changes mid-refill are harmless.
  assign fill_idx = mem_addr_o[OFF+IW-1:OFF];
  assign fill_tag = mem_addr_o[31:OFF+IW];

  assign hit           = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
  assign miss_start    = (state == IDLE) && !hit && ic_repl_permit_i;
  assign instr_hit_f_o = hit;
  assign instr_f_o     = data_mem[idx][word];
  assign unused_bits   = ^pc_f_i[1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      valid      <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            mem_addr_o <= line_addr;
            mem_req_o  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_ready_i) begin
            mem_req_o       <= 1'b0;
            valid[fill_idx] <= 1'b0;
            cnt             <= '0;
            state           <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether they are trusted.
  always_ff @(posedge clk_i) begin
    if (!reset_i && state == REQ && mem_ready_i)
      tag_mem[fill_idx] <= fill_tag;
    if (!reset_i && state == FILL && mem_rvalid_i)
      data_mem[fill_idx][cnt] <= mem_rdata_i;
  end

`ifdef IC_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ic_hit_cnt_o  <= '0;
      ic_miss_cnt_o <= '0;
    end else begin
      if (hit && ic_hit_cnt_o != 32'hFFFF_FFFF)
        ic_hit_cnt_o <= ic_hit_cnt_o + 32'd1;
      if (miss_start && ic_miss_cnt_o != 32'hFFFF_FFFF)
        ic_miss_cnt_o <= ic_miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Self-checking bench for ic_refill_ctrl: directed scenarios plus randomized fetches
// checked against a line-level cache model; counters checked when IC_PERF_CNT_EN is set.
module tb_ic_refill_ctrl;

  localparam int SETS = 32;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        permit;
  logic [31:0] instr;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef IC_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  ic_refill_ctrl #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .pc_f_i           (pc),
    .ic_repl_permit_i (permit),
    .instr_f_o        (instr),
    .instr_hit_f_o    (hit),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_ready_i      (mem_ready),
    .mem_rvalid_i     (mem_rvalid),
    .mem_rdata_i      (mem_rdata)
`ifdef IC_PERF_CNT_EN
    ,
    .ic_hit_cnt_o     (hit_cnt),
    .ic_miss_cnt_o    (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Line-level model of cache contents: which line address each set holds and its words.
  bit          mvalid [SETS];
  logic [31:0] mline  [SETS];
  logic [31:0] mdata  [SETS][LW];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / (LW * 4)) % SETS);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % LW);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return (a / (LW * 4)) * (LW * 4);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[idx_of(a)] && (mline[idx_of(a)] == line_of(a));
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] p);
    reset = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b0; permit = 1'b0; pc = p;
    next_cycle();
    @(negedge clk);
    check_output("reset_hit", hit, 0);
    check_output("reset_req", mem_req, 0);
    check_output("reset_addr", mem_addr, 0);
    for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
`ifdef IC_PERF_CNT_EN
    check_output("reset_hit_cnt", hit_cnt, 0);
    check_output("reset_miss_cnt", miss_cnt, 0);
`endif
    reset = 1'b0;
    next_cycle();
  endtask

  // One IDLE cycle expected to hit; stray read beats are thrown in to show they are ignored.
  task automatic check_idle_hit(input logic [31:0] a);
    pc = a; permit = 1'($urandom); mem_ready = 1'($urandom);
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    @(negedge clk);
    check_output("idle_hit", hit, 1);
    check_output("idle_instr", instr, mdata[idx_of(a)][word_of(a)]);
    check_output("idle_no_req", mem_req, 0);
    exp_hits++;
    next_cycle();
  endtask

  task automatic hold_no_permit(input logic [31:0] a, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      pc = a; permit = 1'b0; mem_ready = 1'($urandom);
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      check_output("gate_no_req", mem_req, 0);
      check_output("gate_no_hit", hit, 0);
      next_cycle();
    end
  endtask

  // Drive a full miss transaction as the memory side; abort_after < LW resets mid-fill.
  task automatic refill(input logic [31:0] addr, input int ready_delay, input int max_gap,
                        input bit wiggle, input bit use_base, input logic [31:0] base,
                        input int abort_after);
    int s;
    int gap;
    logic [31:0] d;
    s = idx_of(addr);
    pc = addr; permit = 1'b1; mem_ready = 1'b0;
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    @(negedge clk);
    check_output("miss_hit", hit, 0);
    check_output("miss_no_req_yet", mem_req, 0);
    exp_misses++;
    next_cycle();
    for (int i = 0; i <= ready_delay; i++) begin
      if (wiggle) pc = $urandom & 32'hFFFF_FFFC;
      permit = 1'($urandom); mem_ready = (i == ready_delay);
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      check_output("req_active", mem_req, 1);
      check_output("req_addr", mem_addr, line_of(addr));
      check_output("req_no_hit", hit, 0);
      next_cycle();
    end
    mvalid[s] = 1'b0;
    mline[s]  = line_of(addr);
    for (int b = 0; b < LW; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        if (wiggle) pc = $urandom & 32'hFFFF_FFFC;
        permit = 1'($urandom); mem_ready = 1'($urandom); mem_rvalid = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        check_output("fill_gap_no_req", mem_req, 0);
        check_output("fill_gap_no_hit", hit, 0);
        next_cycle();
      end
      if (b == abort_after) begin
        apply_reset(addr);
        return;
      end
      d = use_base ? base + 32'(b) : $urandom;
      if (wiggle) pc = $urandom & 32'hFFFF_FFFC;
      permit = 1'($urandom); mem_ready = 1'($urandom); mem_rvalid = 1'b1; mem_rdata = d;
      @(negedge clk);
      check_output("fill_beat_no_req", mem_req, 0);
      check_output("fill_beat_no_hit", hit, 0);
      mdata[s][b] = d;
      next_cycle();
    end
    mvalid[s] = 1'b1;
    pc = addr; permit = 1'($urandom); mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check_output("fill_done_hit", hit, 1);
    check_output("fill_done_instr", instr, mdata[s][word_of(addr)]);
    check_output("fill_done_no_req", mem_req, 0);
    exp_hits++;
    next_cycle();
  endtask

  logic [31:0] tags [4];
  logic [31:0] a;

  initial begin
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h7FFFF; tags[3] = 32'h12345;
    reset = 1'b1; pc = '0; permit = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    next_cycle();
    apply_reset(32'h100);

    // Cold miss with a two-cycle accept delay and back-to-back beats.
    refill(32'h100, 2, 0, 1'b0, 1'b1, 32'hA0, LW);
    check_idle_hit(32'h10C);
    check_idle_hit(32'h104);

    // Miss held without permission, then released.
    hold_no_permit(32'h200, 3);
    refill(32'h200, 0, 0, 1'b0, 1'b0, '0, LW);

    // Same index, different tag evicts the earlier line.
    refill(32'h1100, 0, 0, 1'b1, 1'b1, 32'hB0, LW);
    check_idle_hit(32'h1100);
    check_idle_hit(32'h1108);

    // Gapped fill, preceded by stray beats while idle.
    check_idle_hit(32'h200);
    check_idle_hit(32'h204);
    refill(32'h300, 1, 3, 1'b1, 1'b0, '0, LW);
    check_idle_hit(32'h308);

    // 0x100 was evicted, so it misses again; reset after two beats.
    refill(32'h100, 0, 0, 1'b0, 1'b1, 32'hC0, 2);
    refill(32'h100, 1, 0, 1'b0, 1'b1, 32'hD0, LW);
    for (int k = 1; k < 5; k++) check_idle_hit(32'h100 + 32'(4 * k) - 32'h4 * 32'(k / 4));
`ifdef IC_PERF_CNT_EN
    check_output("perf_miss_cnt", miss_cnt, 32'(exp_misses));
    check_output("perf_hit_cnt", hit_cnt, 32'(exp_hits));
`endif

    // Randomized fetches over a few sets and conflicting tags.
    for (int n = 0; n < 80; n++) begin
      a = (tags[$urandom_range(0, 3)] << 9) | (32'($urandom_range(0, 7)) << 4)
          | (32'($urandom_range(0, LW - 1)) << 2);
      if (model_hit(a)) begin
        check_idle_hit(a);
      end else begin
        hold_no_permit(a, int'($urandom_range(0, 2)));
        refill(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, 1'b0, '0, LW);
      end
    end
`ifdef IC_PERF_CNT_EN
    check_output("perf_final_miss_cnt", miss_cnt, 32'(exp_misses));
    check_output("perf_final_hit_cnt", hit_cnt, 32'(exp_hits));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
